// File: rtl/liteeth_sram_fifo_ctrl_if.sv
// Valid/ready word stream used on both sides of the SRAM FIFO controller.
// The master drives valid and data; the slave answers with ready.
interface liteeth_sram_fifo_ctrl_if #(
  parameter int DATA_W = 48
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/liteeth_sram_fifo_ctrl.sv
// FIFO controller around a 1RW + 1R SRAM macro.
// Accepted words are written through port 0. Port 1 prefetches into a
// 2-entry output buffer, so the head word falls through at one word per cycle.
// The extra buffer slots raise the capacity to DEPTH+2 words.
module liteeth_sram_fifo_ctrl #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  liteeth_sram_fifo_ctrl_if.slave  sink,
  liteeth_sram_fifo_ctrl_if.master source,
  output logic [ADDR_W+1:0]     level,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_W-1:0]     sram_addr1,
  input  logic [DATA_W-1:0]     sram_dout1
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   sram_cnt;
  logic              inflight;
  logic [DATA_W-1:0] ob [2];
  logic [1:0]        ob_cnt;

  logic              wr;
  logic              rd;
  logic              pop;
  logic [1:0]        cnt_after_pop;
  logic [1:0]        ob_cnt_next;
  logic [DATA_W-1:0] ob0_next;
  logic [DATA_W-1:0] ob1_next;
  logic [2:0]        ob_claim;

  // Stream handshakes and macro pins, all combinational from registered state.
  // Port 1 only reads addresses whose write retired on an earlier edge, so the
  // two ports never touch the same live location in one cycle.
  always_comb begin
    sram_cnt     = wptr - rptr;
    sink.ready   = rst_n & ~flush & (sram_cnt != FULL_CNT);
    wr           = sink.valid & sink.ready;
    source.valid = (ob_cnt != 2'd0);
    source.data  = ob[0];
    pop          = source.valid & source.ready;
    ob_claim     = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    rd           = rst_n & ~flush & (sram_cnt != '0) & (ob_claim < 3'd2);

    sram_csb0    = ~wr;
    sram_web0    = ~wr;
    sram_addr0   = wptr[ADDR_W-1:0];
    sram_din0    = sink.data;
    sram_csb1    = ~rd;
    sram_addr1   = rptr[ADDR_W-1:0];

    level        = {1'b0, sram_cnt}
                 + {{(ADDR_W+1){1'b0}}, inflight}
                 + {{ADDR_W{1'b0}}, ob_cnt};
  end

  // Output buffer next state: shift on pop, then place returning read data at the tail.
  always_comb begin
    ob0_next      = ob[0];
    ob1_next      = ob[1];
    cnt_after_pop = ob_cnt - {1'b0, pop};
    if (pop) begin
      ob0_next = ob[1];
    end
    if (inflight) begin
      if (cnt_after_pop == 2'd0) begin
        ob0_next = sram_dout1;
      end else begin
        ob1_next = sram_dout1;
      end
    end
    ob_cnt_next = cnt_after_pop + {1'b0, inflight};
  end

  // Pointer, in-flight and occupancy registers; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      inflight <= rd;
      ob_cnt   <= ob_cnt_next;
    end
  end

  // Buffer data needs no reset; ob_cnt alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    ob[0] <= ob0_next;
    ob[1] <= ob1_next;
  end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Bench for liteeth_sram_fifo_ctrl.
// A behavioural SRAM macro is attached to the controller, and a queue-level
// reference FIFO predicts the controller outputs every cycle.
module tb_liteeth_sram_fifo_ctrl;

  localparam int DATA_W = 48;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [ADDR_W+1:0] level;
  logic              sram_csb0, sram_web0, sram_csb1;
  logic [ADDR_W-1:0] sram_addr0, sram_addr1;
  logic [DATA_W-1:0] sram_din0, sram_dout1;

  liteeth_sram_fifo_ctrl_if #(.DATA_W(DATA_W)) sink_if ();
  liteeth_sram_fifo_ctrl_if #(.DATA_W(DATA_W)) source_if ();

  liteeth_sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .sink       (sink_if),
    .source     (source_if),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  always #5 clk = ~clk;

  // Behavioural 32x48 macro: port 0 writes, port 1 registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  int errors = 0;
  int checks = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words in SRAM, one word in flight, and the output buffer.
  logic [DATA_W-1:0] sq [$];
  logic [DATA_W-1:0] obq [$];
  logic [DATA_W-1:0] popped [$];
  bit                infl = 1'b0;
  logic [DATA_W-1:0] infl_data;
  int                wa = 0;
  int                ra = 0;
  bit                model_live = 1'b0;

  function automatic bit f_in_ready();
    return rst_n && !flush && (sq.size() != DEPTH);
  endfunction

  function automatic bit f_wr();
    return sink_if.valid && f_in_ready();
  endfunction

  function automatic bit f_pop();
    return (obq.size() != 0) && source_if.ready;
  endfunction

  function automatic bit f_rd();
    return rst_n && !flush && (sq.size() != 0) &&
           ((obq.size() + int'(infl) - int'(f_pop())) < 2);
  endfunction

  // Advance the reference FIFO on every clock edge.
  always @(posedge clk) begin : model_update
    bit m_wr, m_pop, m_rd;
    logic [DATA_W-1:0] rd_word;
    if (!rst_n || flush) begin
      sq.delete();
      obq.delete();
      infl <= 1'b0;
      wa   <= 0;
      ra   <= 0;
    end else begin
      m_wr    = f_wr();
      m_pop   = f_pop();
      m_rd    = f_rd();
      rd_word = '0;
      if (m_rd) rd_word = sq[0];
      if (m_pop) void'(obq.pop_front());
      if (infl) obq.push_back(infl_data);
      if (m_rd) void'(sq.pop_front());
      if (m_wr) sq.push_back(sink_if.data);
      infl      <= m_rd;
      infl_data <= rd_word;
      wa        <= m_wr ? (wa + 1) % DEPTH : wa;
      ra        <= m_rd ? (ra + 1) % DEPTH : ra;
    end
    model_live <= 1'b1;
  end

  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data;

  // Compare the DUT against the model mid-cycle and log every word consumed.
  always @(negedge clk) begin
    if (model_live) begin
      check_output("in_ready", sink_if.ready, f_in_ready());
      check_output("out_valid", source_if.valid, obq.size() != 0);
      check_output("level", level, 64'(sq.size() + int'(infl) + obq.size()));
      check_output("csb0", sram_csb0, !f_wr());
      check_output("web0", sram_web0, !f_wr());
      check_output("csb1", sram_csb1, !f_rd());
      if (f_wr()) begin
        check_output("addr0", sram_addr0, wa);
        check_output("din0", sram_din0, sink_if.data);
      end
      if (f_rd()) check_output("addr1", sram_addr1, ra);
      if (obq.size() != 0) check_output("out_data", source_if.data, obq[0]);
      if (prev_hold && source_if.valid) check_output("hold_stable", source_if.data, prev_data);
      if (rst_n && !flush && source_if.valid && source_if.ready) popped.push_back(source_if.data);
    end
    prev_hold <= rst_n && !flush && source_if.valid && !source_if.ready;
    prev_data <= source_if.data;
  end

  task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    sink_if.valid   = v;
    sink_if.data    = d;
    source_if.ready = r;
    flush           = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_popped(input string name, input int base, input int n);
    check_output({name, "_count"}, popped.size(), n);
    for (int i = 0; i < n && i < popped.size(); i++)
      check_output({name, "_word"}, popped[i], 64'(base + i));
  endtask

  initial begin
    int accepted;
    logic rdy_now;
    logic [DATA_W-1:0] rnd;
    rst_n = 1'b0;
    sink_if.valid = 1'b0;
    sink_if.data = '0;
    source_if.ready = 1'b0;
    flush = 1'b0;
    #1;

    // Reset, then a single word
    for (int i = 0; i < 3; i++) apply_stimulus(0, '0, 0, 0);
    check_output("rst_level", level, 0);
    check_output("rst_out_valid", source_if.valid, 0);
    check_output("rst_in_ready", sink_if.ready, 0);
    check_output("rst_csb0", sram_csb0, 1);
    check_output("rst_csb1", sram_csb1, 1);
    rst_n = 1'b1;
    apply_stimulus(0, '0, 0, 0);
    apply_stimulus(1, 48'h0000_0000_ABCD, 0, 0);
    check_output("single_level_n1", level, 1);
    check_output("single_valid_n1", source_if.valid, 0);
    apply_stimulus(0, '0, 0, 0);
    check_output("single_valid_n2", source_if.valid, 0);
    check_output("single_level_n2", level, 1);
    apply_stimulus(0, '0, 0, 0);
    check_output("single_valid_n3", source_if.valid, 1);
    check_output("single_data_n3", source_if.data, 48'h0000_0000_ABCD);
    check_output("single_level_n3", level, 1);
    apply_stimulus(0, '0, 1, 0);
    check_output("single_level_after_pop", level, 0);

    // Streaming 0..99 with the consumer always ready
    popped.delete();
    for (int i = 0; i < 100; i++) apply_stimulus(1, 48'(i), 1, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, '0, 1, 0);
    check_popped("stream", 0, 100);

    // Fill to capacity with the consumer stalled, then drain
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      rdy_now = sink_if.ready;
      apply_stimulus(1, 48'(1000 + accepted), 0, 0);
      if (rdy_now) accepted++;
    end
    for (int i = 0; i < 3; i++) apply_stimulus(0, '0, 0, 0);
    check_output("fill_accepted", accepted, 34);
    check_output("fill_level", level, 34);
    check_output("fill_csb1", sram_csb1, 1);
    check_output("fill_in_ready", sink_if.ready, 0);
    popped.delete();
    for (int i = 0; i < 40; i++) apply_stimulus(0, '0, 1, 0);
    check_popped("drain", 1000, 34);
    check_output("drain_level", level, 0);

    // Pointer wrap-around: five rounds of 20 in / 20 out
    for (int r = 0; r < 5; r++) begin
      popped.delete();
      for (int i = 0; i < 20; i++) apply_stimulus(1, 48'(2000 + r * 20 + i), 0, 0);
      for (int i = 0; i < 25; i++) apply_stimulus(0, '0, 1, 0);
      check_popped("wrap", 2000 + r * 20, 20);
    end

    // Flush with ten words held and a read in flight
    for (int i = 0; i < 10; i++) apply_stimulus(1, 48'(3000 + i), 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, '0, 0, 0);
    check_output("preflush_level_a", level, 10);
    apply_stimulus(1, 48'(3010), 1, 0);
    check_output("preflush_level_b", level, 10);
    apply_stimulus(0, '0, 0, 1);
    check_output("flush_level", level, 0);
    check_output("flush_out_valid", source_if.valid, 0);
    popped.delete();
    apply_stimulus(1, 48'h5A5A, 0, 0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, '0, 0, 0);
    check_output("postflush_valid", source_if.valid, 1);
    check_output("postflush_data", source_if.data, 48'h5A5A);
    for (int i = 0; i < 4; i++) apply_stimulus(0, '0, 1, 0);
    check_popped("postflush", 'h5A5A, 1);

    // Random valid/ready traffic with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      rnd = 48'({$urandom(), $urandom()});
      apply_stimulus(1'($urandom % 2), rnd, 1'($urandom % 2), 1'(($urandom % 97) == 0));
    end
    for (int i = 0; i < 40; i++) apply_stimulus(0, '0, 1, 0);
    check_output("random_final_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
